// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, write-back select encodings and immediate helpers
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // 32-bit sign-extended immediate for the given format; IMM_NONE yields 0.
    function automatic logic [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] ins);
        case (fmt)
            IMM_I:   gen_imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   gen_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   gen_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   gen_imm = {ins[31:12], 12'b0};
            IMM_J:   gen_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: gen_imm = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - 2-read/1-write register file with write-through bypass and hardwired x0
// Ports: clk, rst (async, active-high); we/wa/wd write port; ra1/ra2 read indices; rd1/rd2 read data.
module id_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int RA_W  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RA_W-1:0] wa,
    input  logic [XLEN-1:0] wd,
    input  logic [RA_W-1:0] ra1,
    input  logic [RA_W-1:0] ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [NREGS];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    // A read of the register being written this cycle sees the new value.
    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (we && wa == ra1) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (we && wa == ra2) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - RV32I decode stage with register file and ID/EXE pipeline register
// Ports: IF/ID instruction/pc/valid in; stall/flush from hazard unit; WB write port;
//        *_ID_EXE decoded operands, immediate and controls out; load_use_HZRD combinational out.
module id_stage_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PC_W  = 15,
    parameter int NREGS = 32,
    parameter int RA_W  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_IF_ID,
    input  logic [31:0]     instruction_IF_ID,
    input  logic [PC_W-1:0] pc_IF_ID,
    input  logic            stall_HZRD,
    input  logic            flush_HZRD,
    input  logic            RegWrite_WB,
    input  logic [RA_W-1:0] write_reg_WB,
    input  logic [XLEN-1:0] write_data_WB,
    output logic            valid_ID_EXE,
    output logic [XLEN-1:0] read_data1_ID_EXE,
    output logic [XLEN-1:0] read_data2_ID_EXE,
    output logic [XLEN-1:0] immediate_ID_EXE,
    output logic [RA_W-1:0] rs1_ID_EXE,
    output logic [RA_W-1:0] rs2_ID_EXE,
    output logic [RA_W-1:0] rd_ID_EXE,
    output logic [PC_W-1:0] pc_ID_EXE,
    output logic [3:0]      ALUOp_ID_EXE,
    output logic            ALUSrc_ID_EXE,
    output logic [3:0]      MemRead_ID_EXE,
    output logic [3:0]      MemWrite_ID_EXE,
    output logic [1:0]      MemtoReg_ID_EXE,
    output logic            RegWrite_ID_EXE,
    output logic            branch_ID_EXE,
    output logic            JAL_ID_EXE,
    output logic            JALR_ID_EXE,
    output logic [PC_W-1:0] branch_address_ID_EXE,
    output logic [PC_W-1:0] jalr_address_ID_EXE,
    output logic            illegal_ID_EXE,
    output logic            load_use_HZRD
);

    localparam int W = 3 * XLEN + 3 * RA_W + 3 * PC_W + 21;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [RA_W-1:0] rs1_f, rs2_f, rd_f;
    assign opcode = instruction_IF_ID[6:0];
    assign f3     = instruction_IF_ID[14:12];
    assign rs1_f  = instruction_IF_ID[15 +: RA_W];
    assign rs2_f  = instruction_IF_ID[20 +: RA_W];
    assign rd_f   = instruction_IF_ID[7 +: RA_W];

    imm_fmt_e   fmt;
    logic       rs1_used, rs2_used, rd_used;
    logic [3:0] d_aluop, d_mr, d_mw;
    logic [1:0] d_m2r;
    logic       d_alusrc, d_br, d_jal, d_jalr, d_ill;

    always_comb begin
        fmt      = IMM_NONE;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        rd_used  = 1'b0;
        d_aluop  = 4'b0000;
        d_alusrc = 1'b0;
        d_mr     = 4'b0000;
        d_mw     = 4'b0000;
        d_m2r    = M2R_ALU;
        d_br     = 1'b0;
        d_jal    = 1'b0;
        d_jalr   = 1'b0;
        d_ill    = 1'b0;
        case (opcode)
            OP_R: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                rd_used  = 1'b1;
                d_aluop  = {instruction_IF_ID[30], f3};
            end
            OP_IMM: begin
                rs1_used = 1'b1;
                rd_used  = 1'b1;
                fmt      = IMM_I;
                d_alusrc = 1'b1;
                // Only SRAI carries funct7[5] into the ALU op; other I-type ops use imm[10] as data.
                d_aluop  = {instruction_IF_ID[30] & (f3 == 3'b101), f3};
            end
            OP_LOAD: begin
                rs1_used = 1'b1;
                rd_used  = 1'b1;
                fmt      = IMM_I;
                d_alusrc = 1'b1;
                d_mr     = {1'b1, f3};
                d_m2r    = M2R_MEM;
            end
            OP_STORE: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                fmt      = IMM_S;
                d_alusrc = 1'b1;
                d_mw     = {1'b1, f3};
            end
            OP_BRANCH: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                fmt      = IMM_B;
                d_br     = 1'b1;
            end
            OP_JAL: begin
                rd_used = 1'b1;
                fmt     = IMM_J;
                d_jal   = 1'b1;
                d_m2r   = M2R_PC4;
            end
            OP_JALR: begin
                rs1_used = 1'b1;
                rd_used  = 1'b1;
                fmt      = IMM_I;
                d_alusrc = 1'b1;
                d_jalr   = 1'b1;
                d_m2r    = M2R_PC4;
            end
            OP_LUI, OP_AUIPC: begin
                rd_used  = 1'b1;
                fmt      = IMM_U;
                d_alusrc = 1'b1;
            end
            default: begin
                // rs1 still counts as a source so the hazard rule stays uniform.
                rs1_used = 1'b1;
                d_ill    = 1'b1;
            end
        endcase
    end

    // Unused source indices collapse to x0, which also makes their operands read as 0.
    logic [RA_W-1:0] ra1, ra2, rd_out;
    assign ra1    = rs1_used ? rs1_f : '0;
    assign ra2    = rs2_used ? rs2_f : '0;
    assign rd_out = rd_used ? rd_f : '0;

    logic [XLEN-1:0] rf_rd1, rf_rd2;

    id_regfile #(
        .XLEN (XLEN),
        .NREGS(NREGS),
        .RA_W (RA_W)
    ) u_regfile (
        .clk(clk),
        .rst(reset),
        .we (RegWrite_WB),
        .wa (write_reg_WB),
        .wd (write_data_WB),
        .ra1(ra1),
        .ra2(ra2),
        .rd1(rf_rd1),
        .rd2(rf_rd2)
    );

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic [PC_W-1:0] imm_pc, baddr, jsum, jaddr;
    logic [XLEN-1:0] op1;
    logic            d_rw;

    assign imm32  = gen_imm(fmt, instruction_IF_ID);
    assign imm    = XLEN'($signed(imm32));
    assign imm_pc = imm[PC_W-1:0];
    assign baddr  = pc_IF_ID + imm_pc;
    assign jsum   = rf_rd1[PC_W-1:0] + imm_pc;
    assign jaddr  = {jsum[PC_W-1:1], 1'b0};
    assign d_rw   = rd_used && (rd_f != '0);

    always_comb begin
        op1 = rf_rd1;
        if (opcode == OP_LUI) begin
            op1 = '0;
        end else if (opcode == OP_AUIPC) begin
            op1 = XLEN'(pc_IF_ID);
        end
    end

    logic [W-1:0] d_bus, q_bus;

    assign d_bus = {1'b1, op1, rf_rd2, imm, ra1, ra2, rd_out, pc_IF_ID,
                    d_aluop, d_alusrc, d_mr, d_mw, d_m2r, d_rw,
                    d_br, d_jal, d_jalr, baddr, jaddr, d_ill};

    // Flush beats stall; an empty IF/ID slot loads the same all-zero bubble as a flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_bus <= '0;
        end else if (flush_HZRD) begin
            q_bus <= '0;
        end else if (!stall_HZRD) begin
            q_bus <= valid_IF_ID ? d_bus : '0;
        end
    end

    assign {valid_ID_EXE, read_data1_ID_EXE, read_data2_ID_EXE, immediate_ID_EXE,
            rs1_ID_EXE, rs2_ID_EXE, rd_ID_EXE, pc_ID_EXE,
            ALUOp_ID_EXE, ALUSrc_ID_EXE, MemRead_ID_EXE, MemWrite_ID_EXE, MemtoReg_ID_EXE,
            RegWrite_ID_EXE, branch_ID_EXE, JAL_ID_EXE, JALR_ID_EXE,
            branch_address_ID_EXE, jalr_address_ID_EXE, illegal_ID_EXE} = q_bus;

    // ra1/ra2 are already zero for unused sources and rd_ID_EXE is nonzero here, so unused fields never match.
    assign load_use_HZRD = valid_ID_EXE && MemRead_ID_EXE[3] && (rd_ID_EXE != '0) && valid_IF_ID &&
                           ((rd_ID_EXE == ra1) || (rd_ID_EXE == ra2));

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - self-checking bench for id_stage_pipe
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_IF_ID;
    logic [31:0] instruction_IF_ID;
    logic [14:0] pc_IF_ID;
    logic        stall_HZRD, flush_HZRD;
    logic        RegWrite_WB;
    logic [4:0]  write_reg_WB;
    logic [31:0] write_data_WB;
    logic        valid_ID_EXE;
    logic [31:0] read_data1_ID_EXE, read_data2_ID_EXE, immediate_ID_EXE;
    logic [4:0]  rs1_ID_EXE, rs2_ID_EXE, rd_ID_EXE;
    logic [14:0] pc_ID_EXE;
    logic [3:0]  ALUOp_ID_EXE;
    logic        ALUSrc_ID_EXE;
    logic [3:0]  MemRead_ID_EXE, MemWrite_ID_EXE;
    logic [1:0]  MemtoReg_ID_EXE;
    logic        RegWrite_ID_EXE, branch_ID_EXE, JAL_ID_EXE, JALR_ID_EXE;
    logic [14:0] branch_address_ID_EXE, jalr_address_ID_EXE;
    logic        illegal_ID_EXE, load_use_HZRD;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .reset(reset), .valid_IF_ID(valid_IF_ID),
        .instruction_IF_ID(instruction_IF_ID), .pc_IF_ID(pc_IF_ID),
        .stall_HZRD(stall_HZRD), .flush_HZRD(flush_HZRD),
        .RegWrite_WB(RegWrite_WB), .write_reg_WB(write_reg_WB), .write_data_WB(write_data_WB),
        .valid_ID_EXE(valid_ID_EXE), .read_data1_ID_EXE(read_data1_ID_EXE),
        .read_data2_ID_EXE(read_data2_ID_EXE), .immediate_ID_EXE(immediate_ID_EXE),
        .rs1_ID_EXE(rs1_ID_EXE), .rs2_ID_EXE(rs2_ID_EXE), .rd_ID_EXE(rd_ID_EXE),
        .pc_ID_EXE(pc_ID_EXE), .ALUOp_ID_EXE(ALUOp_ID_EXE), .ALUSrc_ID_EXE(ALUSrc_ID_EXE),
        .MemRead_ID_EXE(MemRead_ID_EXE), .MemWrite_ID_EXE(MemWrite_ID_EXE),
        .MemtoReg_ID_EXE(MemtoReg_ID_EXE), .RegWrite_ID_EXE(RegWrite_ID_EXE),
        .branch_ID_EXE(branch_ID_EXE), .JAL_ID_EXE(JAL_ID_EXE), .JALR_ID_EXE(JALR_ID_EXE),
        .branch_address_ID_EXE(branch_address_ID_EXE), .jalr_address_ID_EXE(jalr_address_ID_EXE),
        .illegal_ID_EXE(illegal_ID_EXE), .load_use_HZRD(load_use_HZRD)
    );

    typedef struct {
        logic        valid;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [14:0] pc;
        logic [3:0]  aluop;
        logic        alusrc;
        logic [3:0]  mr, mw;
        logic [1:0]  m2r;
        logic        rw, br, jal, jalr, ill;
        logic [1:0]  achk;   // bit0: check branch_address, bit1: check jalr_address
        logic [14:0] baddr, jaddr;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [14:0] pc;
        logic        vin;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    exp_t zero_e, tmp_e;
    vec_t tbl[14];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, ".valid"},    32'(valid_ID_EXE),      32'(e.valid));
        chk({tag, ".rd1"},      read_data1_ID_EXE,      e.rd1);
        chk({tag, ".rd2"},      read_data2_ID_EXE,      e.rd2);
        chk({tag, ".imm"},      immediate_ID_EXE,       e.imm);
        chk({tag, ".rs1"},      32'(rs1_ID_EXE),        32'(e.rs1));
        chk({tag, ".rs2"},      32'(rs2_ID_EXE),        32'(e.rs2));
        chk({tag, ".rd"},       32'(rd_ID_EXE),         32'(e.rd));
        chk({tag, ".pc"},       32'(pc_ID_EXE),         32'(e.pc));
        chk({tag, ".aluop"},    32'(ALUOp_ID_EXE),      32'(e.aluop));
        chk({tag, ".alusrc"},   32'(ALUSrc_ID_EXE),     32'(e.alusrc));
        chk({tag, ".memread"},  32'(MemRead_ID_EXE),    32'(e.mr));
        chk({tag, ".memwrite"}, 32'(MemWrite_ID_EXE),   32'(e.mw));
        chk({tag, ".memtoreg"}, 32'(MemtoReg_ID_EXE),   32'(e.m2r));
        chk({tag, ".regwrite"}, 32'(RegWrite_ID_EXE),   32'(e.rw));
        chk({tag, ".branch"},   32'(branch_ID_EXE),     32'(e.br));
        chk({tag, ".jal"},      32'(JAL_ID_EXE),        32'(e.jal));
        chk({tag, ".jalr"},     32'(JALR_ID_EXE),       32'(e.jalr));
        chk({tag, ".illegal"},  32'(illegal_ID_EXE),    32'(e.ill));
        if (e.achk[0]) chk({tag, ".baddr"}, 32'(branch_address_ID_EXE), 32'(e.baddr));
        if (e.achk[1]) chk({tag, ".jaddr"}, 32'(jalr_address_ID_EXE), 32'(e.jaddr));
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got output with no expectation", tag);
        end else begin
            e = sb.pop_front();
            check_out(tag, e);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic [14:0] pc, input logic vin,
                         input exp_t e, input string tag);
        instruction_IF_ID = ins;
        pc_IF_ID          = pc;
        valid_IF_ID       = vin;
        sb.push_back(e);
        tick(tag);
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        RegWrite_WB   = 1'b1;
        write_reg_WB  = r;
        write_data_WB = d;
        drive(32'h0, 15'h0, 1'b0, zero_e, "preload");
        RegWrite_WB   = 1'b0;
    endtask

    initial begin
        zero_e = '{default: '0};
        //            valid rd1         rd2         imm           rs1   rs2   rd     pc        aluop    src   mr       mw       m2r    rw    br    jal   jalr  ill   achk   baddr     jaddr
        tbl[0]  = '{32'h00d30293, 15'h0010, 1'b1, '{1'b1, 32'h7,  32'h0,  32'd13,       5'd6, 5'd0, 5'd5,  15'h0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 15'h0,    15'h0}};
        tbl[1]  = '{32'hf853ae23, 15'h0014, 1'b1, '{1'b1, 32'h20, 32'h55, 32'hFFFFFF9C, 5'd7, 5'd5, 5'd0,  15'h0014, 4'b0000, 1'b1, 4'b0000, 4'b1010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 15'h0,    15'h0}};
        tbl[2]  = '{32'h001283B3, 15'h0018, 1'b1, '{1'b1, 32'h55, 32'h11, 32'h0,        5'd5, 5'd1, 5'd7,  15'h0018, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 15'h0,    15'h0}};
        tbl[3]  = '{32'h40638433, 15'h001C, 1'b1, '{1'b1, 32'h20, 32'h7,  32'h0,        5'd7, 5'd6, 5'd8,  15'h001C, 4'b1000, 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 15'h0,    15'h0}};
        tbl[4]  = '{32'h40335493, 15'h0020, 1'b1, '{1'b1, 32'h7,  32'h0,  32'h403,      5'd6, 5'd0, 5'd9,  15'h0020, 4'b1101, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 15'h0,    15'h0}};
        tbl[5]  = '{32'h0080A283, 15'h0024, 1'b1, '{1'b1, 32'h11, 32'h0,  32'd8,        5'd1, 5'd0, 5'd5,  15'h0024, 4'b0000, 1'b1, 4'b1010, 4'b0000, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 15'h0,    15'h0}};
        tbl[6]  = '{32'h12345537, 15'h0028, 1'b1, '{1'b1, 32'h0,  32'h0,  32'h12345000, 5'd0, 5'd0, 5'd10, 15'h0028, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 15'h0,    15'h0}};
        tbl[7]  = '{32'h00001597, 15'h0040, 1'b1, '{1'b1, 32'h40, 32'h0,  32'h1000,     5'd0, 5'd0, 5'd11, 15'h0040, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 15'h0,    15'h0}};
        tbl[8]  = '{32'hFE730CE3, 15'h0100, 1'b1, '{1'b1, 32'h7,  32'h20, 32'hFFFFFFF8, 5'd6, 5'd7, 5'd0,  15'h0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 15'h00F8, 15'h0}};
        tbl[9]  = '{32'h005380E7, 15'h0104, 1'b1, '{1'b1, 32'h20, 32'h0,  32'd5,        5'd7, 5'd0, 5'd1,  15'h0104, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 15'h0,    15'h0024}};
        tbl[10] = '{32'h008000EF, 15'h7FFC, 1'b1, '{1'b1, 32'h0,  32'h0,  32'd8,        5'd0, 5'd0, 5'd1,  15'h7FFC, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 15'h0004, 15'h0}};
        tbl[11] = '{32'h00000000, 15'h0200, 1'b1, '{1'b1, 32'h0,  32'h0,  32'h0,        5'd0, 5'd0, 5'd0,  15'h0200, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 15'h0,    15'h0}};
        tbl[12] = '{32'h00500013, 15'h0204, 1'b1, '{1'b1, 32'h0,  32'h0,  32'd5,        5'd0, 5'd0, 5'd0,  15'h0204, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 15'h0,    15'h0}};
        tbl[13] = '{32'h00d30293, 15'h0208, 1'b0, zero_e};

        reset = 1'b1;
        valid_IF_ID = 1'b0;
        instruction_IF_ID = 32'h0;
        pc_IF_ID = 15'h0;
        stall_HZRD = 1'b0;
        flush_HZRD = 1'b0;
        RegWrite_WB = 1'b0;
        write_reg_WB = 5'd0;
        write_data_WB = 32'h0;
        #12;
        check_out("reset", zero_e);
        chk("reset.load_use", 32'(load_use_HZRD), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        wb_write(5'd1, 32'h11);
        wb_write(5'd5, 32'h55);
        wb_write(5'd6, 32'h7);
        wb_write(5'd7, 32'h20);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].instr, tbl[i].pc, tbl[i].vin, tbl[i].e, $sformatf("vec%0d", i));
        end

        // Same-cycle WB write of x6 is visible to the decode.
        tmp_e = tbl[0].e;
        tmp_e.rd1 = 32'd55;
        RegWrite_WB = 1'b1; write_reg_WB = 5'd6; write_data_WB = 32'd55;
        drive(32'h00d30293, 15'h0010, 1'b1, tmp_e, "bypass");
        RegWrite_WB = 1'b0;
        drive(32'h00d30293, 15'h0010, 1'b1, tmp_e, "bypass_stored");

        // Writes to x0 are neither bypassed nor stored.
        tmp_e = tbl[0].e;
        tmp_e.rd1 = 32'h0;
        tmp_e.rs1 = 5'd0;
        RegWrite_WB = 1'b1; write_reg_WB = 5'd0; write_data_WB = 32'hDEAD;
        drive(32'h00d00293, 15'h0010, 1'b1, tmp_e, "x0_bypass");
        RegWrite_WB = 1'b0;
        drive(32'h00d00293, 15'h0010, 1'b1, tmp_e, "x0_stored");

        // Stall holds the sw for two cycles while a regfile write still lands; flush beats stall.
        drive(tbl[1].instr, tbl[1].pc, 1'b1, tbl[1].e, "sw");
        stall_HZRD = 1'b1;
        RegWrite_WB = 1'b1; write_reg_WB = 5'd9; write_data_WB = 32'h99;
        drive(32'h001283B3, 15'h0018, 1'b1, tbl[1].e, "stall1");
        RegWrite_WB = 1'b0;
        drive(32'h001283B3, 15'h0018, 1'b1, tbl[1].e, "stall2");
        flush_HZRD = 1'b1;
        drive(32'h001283B3, 15'h0018, 1'b1, zero_e, "flush");
        flush_HZRD = 1'b0;
        stall_HZRD = 1'b0;
        tmp_e = tbl[0].e;
        tmp_e.rd1 = 32'h99;
        tmp_e.rs1 = 5'd9;
        tmp_e.pc  = 15'h0030;
        drive(32'h00D48293, 15'h0030, 1'b1, tmp_e, "stall_wb");

        // Load-use detection against lw x5 held in ID/EXE.
        drive(tbl[5].instr, tbl[5].pc, 1'b1, tbl[5].e, "lw");
        instruction_IF_ID = 32'h001283B3; valid_IF_ID = 1'b1; #1;
        chk("lu_add_rs1", 32'(load_use_HZRD), 32'h1);
        instruction_IF_ID = 32'hf853ae23; #1;
        chk("lu_sw_rs2", 32'(load_use_HZRD), 32'h1);
        instruction_IF_ID = 32'h000283B7; #1;
        chk("lu_lui", 32'(load_use_HZRD), 32'h0);
        instruction_IF_ID = 32'h001283B3; valid_IF_ID = 1'b0; #1;
        chk("lu_ifid_invalid", 32'(load_use_HZRD), 32'h0);

        tmp_e = tbl[5].e;
        tmp_e.rd = 5'd0;
        tmp_e.rw = 1'b0;
        drive(32'h0080A003, 15'h0024, 1'b1, tmp_e, "lw_x0");
        instruction_IF_ID = 32'h001003B3; valid_IF_ID = 1'b1; #1;
        chk("lu_rd0", 32'(load_use_HZRD), 32'h0);

        // Asynchronous reset mid-run, then the first edge after release loads normally.
        drive(tbl[2].instr, tbl[2].pc, 1'b1, tbl[2].e, "pre_reset");
        #3;
        reset = 1'b1;
        #1;
        check_out("async_reset", zero_e);
        chk("async_reset.load_use", 32'(load_use_HZRD), 32'h0);
        #2;
        reset = 1'b0;
        tmp_e = zero_e;
        tmp_e.valid = 1'b1; tmp_e.rs1 = 5'd5; tmp_e.rd = 5'd8; tmp_e.pc = 15'h0300;
        tmp_e.alusrc = 1'b1; tmp_e.rw = 1'b1;
        drive(32'h00028413, 15'h0300, 1'b1, tmp_e, "post_reset_x5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
